// File: rtl/lsu_data_ctrl_pkg.sv
// Shared definitions for the LSU data controller: funct3 codes, FSM states,
// and the store lane / alignment helpers.
package lsu_data_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Byte enables depend only on access width (funct3[1:0]) and the low address bits.
    function automatic logic [3:0] lane_be(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] data);
        logic [31:0] w;
        case (funct3[1:0])
            2'b00:   w = {4{data[7:0]}};
            2'b01:   w = {2{data[15:0]}};
            2'b10:   w = data;
            default: w = data;
        endcase
        return w;
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic m;
        case (funct3[1:0])
            2'b01:   m = off[0];
            2'b10:   m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_data_ctrl_load_align.sv
// lsu_load_align: picks the addressed byte/half from a raw read word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_data_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by width-dependent extension.
    always_comb begin
        case (offset)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3)
            F3_B:    data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   data = {24'h000000, byte_s};
            F3_H:    data = {{16{half_s[15]}}, half_s};
            F3_HU:   data = {16'h0000, half_s};
            F3_W:    data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_data_ctrl.sv
// LSU data-memory controller: IDLE/BUSY/DONE handshake with timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of performing them.
module lsu_data_ctrl
    import lsu_data_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic        flush_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] load_data_o,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic        misalign_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [2:0]       funct3_r;
    logic [1:0]       offset_r;
    logic             misaligned_s;
    logic             access_s;
    logic             trap_s;
    logic [31:0]      aligned_s;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned_s = misaligned(funct3_i, addr_i[1:0]);
`else
    assign misaligned_s = 1'b0;
`endif

    lsu_load_align u_align (
        .funct3 (funct3_r),
        .offset (offset_r),
        .rdata  (dmem_rdata_i),
        .data   (aligned_s)
    );

    // Request decode in IDLE; stall covers the launch cycle and the whole BUSY phase.
    always_comb begin
        access_s = 1'b0;
        trap_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            access_s = (mem_read_i | mem_write_i) & ~flush_i & ~misaligned_s;
            trap_s   = (mem_read_i | mem_write_i) & ~flush_i & misaligned_s;
        end else begin
            access_s = 1'b0;
            trap_s   = 1'b0;
        end
        stall_o = access_s | (state_r == ST_BUSY);
    end

    // Controller FSM with registered bus and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= '0;
            funct3_r     <= 3'b000;
            offset_r     <= 2'b00;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'h0000_0000;
            dmem_wdata_o <= 32'h0000_0000;
            dmem_be_o    <= 4'b0000;
            load_data_o  <= 32'h0000_0000;
            bus_err_o    <= 1'b0;
            misalign_o   <= 1'b0;
        end else begin
            bus_err_o  <= 1'b0;
            misalign_o <= trap_s;
            case (state_r)
                ST_IDLE: begin
                    if (access_s) begin
                        state_r      <= ST_BUSY;
                        wait_cnt_r   <= '0;
                        funct3_r     <= funct3_i;
                        offset_r     <= addr_i[1:0];
                        dmem_req_o   <= 1'b1;
                        // A simultaneous read+write is a store.
                        dmem_we_o    <= mem_write_i;
                        dmem_addr_o  <= {addr_i[31:2], 2'b00};
                        dmem_be_o    <= lane_be(funct3_i, addr_i[1:0]);
                        dmem_wdata_o <= mem_write_i ? store_lanes(funct3_i, store_data_i) : 32'h0000_0000;
                    end
                end
                ST_BUSY: begin
                    if (dmem_ready_i) begin
                        state_r    <= ST_DONE;
                        dmem_req_o <= 1'b0;
                        if (!dmem_we_o) begin
                            load_data_o <= aligned_s;
                        end
                    end else if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_r    <= ST_DONE;
                        dmem_req_o <= 1'b0;
                        bus_err_o  <= 1'b1;
                        if (!dmem_we_o) begin
                            load_data_o <= 32'h0000_0000;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    wait_cnt_r <= '0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    dmem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_data_ctrl.sv
// Directed self-checking bench for lsu_data_ctrl with hand-computed expectations.
module tb_lsu_data_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] store_data_i = 32'h0;
    logic        flush_i = 1'b0;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ready_i = 1'b0;
    logic [31:0] dmem_rdata_i = 32'h0;
    logic [31:0] load_data_o;
    logic        stall_o;
    logic        bus_err_o;
    logic        misalign_o;

    always #5 clk = ~clk;

    lsu_data_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .flush_i      (flush_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_ready_i (dmem_ready_i),
        .dmem_rdata_i (dmem_rdata_i),
        .load_data_o  (load_data_o),
        .stall_o      (stall_o),
        .bus_err_o    (bus_err_o),
        .misalign_o   (misalign_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic        obs_req, obs_we, obs_mis, obs_err;
    logic [31:0] obs_addr, obs_wdata, obs_ld;
    logic [3:0]  obs_be;
    int          obs_stalls, obs_busy;

    // Drives one access from IDLE; ready rises in BUSY cycle ready_after (0 = never).
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input int ready_after,
                              input logic flush_idle, input logic flush_busy);
        int guard;
        mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = addr;
        store_data_i = sdata; flush_i = flush_idle;
        #1;
        obs_stalls = stall_o ? 1 : 0;
        obs_busy = 0;
        @(posedge clk); #1;
        mem_read_i = 1'b0; mem_write_i = 1'b0; flush_i = flush_busy;
        #1;
        obs_req = dmem_req_o; obs_we = dmem_we_o; obs_addr = dmem_addr_o;
        obs_wdata = dmem_wdata_o; obs_be = dmem_be_o; obs_mis = misalign_o;
        guard = 0;
        while (stall_o && guard < 40) begin
            obs_stalls++; obs_busy++; guard++;
            dmem_ready_i = (obs_busy == ready_after);
            dmem_rdata_i = rdata;
            @(posedge clk); #1;
            dmem_ready_i = 1'b0;
        end
        n_cmp++;
        if (stall_o !== 1'b0) begin n_err++; $display("FAIL access_bound: stall_o=%b after %0d cycles, required 0", stall_o, guard); end
        obs_ld = load_data_o; obs_err = bus_err_o;
        flush_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (dmem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b expected 0", dmem_req_o); end
        n_cmp++; if ({dmem_we_o, dmem_be_o} !== 5'b0) begin n_err++; $display("FAIL rst_we_be: got %b expected 0", {dmem_we_o, dmem_be_o}); end
        n_cmp++; if ({dmem_addr_o, dmem_wdata_o, load_data_o} !== 96'h0) begin n_err++; $display("FAIL rst_data: got %h expected 0", {dmem_addr_o, dmem_wdata_o, load_data_o}); end
        n_cmp++; if ({stall_o, bus_err_o, misalign_o} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b expected 000", {stall_o, bus_err_o, misalign_o}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lb();
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 2, 1'b0, 1'b0);
        n_cmp++; if (obs_req !== 1'b1) begin n_err++; $display("FAIL lb_req: got %b expected 1", obs_req); end
        n_cmp++; if (obs_addr !== 32'h0000_0100) begin n_err++; $display("FAIL lb_addr: got %h expected 00000100", obs_addr); end
        n_cmp++; if ({obs_we, obs_be} !== 5'b0_1000) begin n_err++; $display("FAIL lb_we_be: got %b expected 01000", {obs_we, obs_be}); end
        n_cmp++; if (obs_stalls !== 3) begin n_err++; $display("FAIL lb_stalls: got %0d expected 3", obs_stalls); end
        n_cmp++; if (obs_ld !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data: got %h expected ffffff80", obs_ld); end
        n_cmp++; if (load_data_o !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_hold: got %h expected ffffff80", load_data_o); end
    endtask

    task automatic test_store_sh();
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h5555_5555, 1, 1'b0, 1'b0);
        n_cmp++; if (obs_addr !== 32'h0000_0200) begin n_err++; $display("FAIL sh_addr: got %h expected 00000200", obs_addr); end
        n_cmp++; if ({obs_we, obs_be} !== 5'b1_1100) begin n_err++; $display("FAIL sh_we_be: got %b expected 11100", {obs_we, obs_be}); end
        n_cmp++; if (obs_wdata !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_wdata: got %h expected abcdabcd", obs_wdata); end
        n_cmp++; if (obs_ld !== 32'hFFFF_FF80) begin n_err++; $display("FAIL sh_keeps_load: got %h expected ffffff80", obs_ld); end
    endtask

    task automatic test_load_variants();
        run_access(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 1, 1'b0, 1'b0);
        n_cmp++; if ({obs_be, obs_ld} !== {4'b1100, 32'h0000_8001}) begin n_err++; $display("FAIL lhu: got be=%b data=%h expected be=1100 data=00008001", obs_be, obs_ld); end
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0, 32'h1234_8765, 3, 1'b0, 1'b0);
        n_cmp++; if ({obs_be, obs_ld} !== {4'b0011, 32'hFFFF_8765}) begin n_err++; $display("FAIL lh: got be=%b data=%h expected be=0011 data=ffff8765", obs_be, obs_ld); end
        run_access(1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h1234_C5FF, 1, 1'b0, 1'b0);
        n_cmp++; if ({obs_be, obs_ld} !== {4'b0010, 32'h0000_00C5}) begin n_err++; $display("FAIL lbu: got be=%b data=%h expected be=0010 data=000000c5", obs_be, obs_ld); end
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
        n_cmp++; if ({obs_be, obs_ld} !== {4'b1111, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL lw: got be=%b data=%h expected be=1111 data=deadbeef", obs_be, obs_ld); end
    endtask

    task automatic test_store_variants();
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 32'h0, 1, 1'b0, 1'b0);
        n_cmp++; if ({obs_be, obs_wdata} !== {4'b0010, 32'hA5A5_A5A5}) begin n_err++; $display("FAIL sb: got be=%b wdata=%h expected be=0010 wdata=a5a5a5a5", obs_be, obs_wdata); end
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_0108, 32'hCAFE_F00D, 32'h0, 2, 1'b0, 1'b0);
        n_cmp++; if ({obs_be, obs_wdata, obs_addr} !== {4'b1111, 32'hCAFE_F00D, 32'h0000_0108}) begin n_err++; $display("FAIL sw: got be=%b wdata=%h addr=%h expected 1111 cafef00d 00000108", obs_be, obs_wdata, obs_addr); end
        run_access(1'b1, 1'b1, 3'b010, 32'h0000_010C, 32'h1111_2222, 32'h3333_4444, 1, 1'b0, 1'b0);
        n_cmp++; if ({obs_we, obs_ld} !== {1'b1, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL rw_as_store: got we=%b data=%h expected we=1 data=deadbeef", obs_we, obs_ld); end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0110, 32'h0, 32'h7777_7777, 0, 1'b0, 1'b0);
        n_cmp++; if (obs_busy !== 16) begin n_err++; $display("FAIL to_busy_cycles: got %0d expected 16", obs_busy); end
        n_cmp++; if (obs_err !== 1'b1) begin n_err++; $display("FAIL to_bus_err: got %b expected 1", obs_err); end
        n_cmp++; if (obs_ld !== 32'h0) begin n_err++; $display("FAIL to_data: got %h expected 00000000", obs_ld); end
        n_cmp++; if ({bus_err_o, stall_o, dmem_req_o} !== 3'b000) begin n_err++; $display("FAIL to_after: got %b expected 000", {bus_err_o, stall_o, dmem_req_o}); end
    endtask

    task automatic test_misalign();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h1122_3344, 1, 1'b0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        n_cmp++; if ({obs_req, obs_mis} !== 2'b01) begin n_err++; $display("FAIL mis_trap: got req=%b mis=%b expected req=0 mis=1", obs_req, obs_mis); end
        n_cmp++; if (obs_stalls !== 0) begin n_err++; $display("FAIL mis_stall: got %0d expected 0", obs_stalls); end
        n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL mis_pulse: got %b expected 0", misalign_o); end
`else
        n_cmp++; if ({obs_req, obs_mis} !== 2'b10) begin n_err++; $display("FAIL mis_off: got req=%b mis=%b expected req=1 mis=0", obs_req, obs_mis); end
        n_cmp++; if (obs_addr !== 32'h0000_0100) begin n_err++; $display("FAIL mis_addr: got %h expected 00000100", obs_addr); end
        n_cmp++; if (obs_ld !== 32'h1122_3344) begin n_err++; $display("FAIL mis_data: got %h expected 11223344", obs_ld); end
`endif
    endtask

    task automatic test_flush();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0114, 32'h0, 32'h0BAD_CAFE, 2, 1'b0, 1'b1);
        n_cmp++; if ({obs_req, obs_ld} !== {1'b1, 32'h0BAD_CAFE}) begin n_err++; $display("FAIL flush_busy: got req=%b data=%h expected req=1 data=0badcafe", obs_req, obs_ld); end
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0118, 32'h0, 32'h1234_5678, 1, 1'b1, 1'b0);
        n_cmp++; if ({obs_req, obs_ld} !== {1'b0, 32'h0BAD_CAFE}) begin n_err++; $display("FAIL flush_idle: got req=%b data=%h expected req=0 data=0badcafe", obs_req, obs_ld); end
        n_cmp++; if (obs_stalls !== 0) begin n_err++; $display("FAIL flush_idle_stall: got %0d expected 0", obs_stalls); end
    endtask

    task automatic test_rst_busy();
        mem_write_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0120; store_data_i = 32'h9999_8888;
        @(posedge clk); #1;
        mem_write_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({dmem_req_o, dmem_we_o, stall_o} !== 3'b111) begin n_err++; $display("FAIL rb_busy: got %b expected 111", {dmem_req_o, dmem_we_o, stall_o}); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({dmem_req_o, dmem_we_o, dmem_be_o} !== 6'b0) begin n_err++; $display("FAIL rb_ctrl: got %b expected 0", {dmem_req_o, dmem_we_o, dmem_be_o}); end
        n_cmp++; if ({dmem_addr_o, dmem_wdata_o, load_data_o} !== 96'h0) begin n_err++; $display("FAIL rb_data: got %h expected 0", {dmem_addr_o, dmem_wdata_o, load_data_o}); end
        n_cmp++; if ({stall_o, bus_err_o, misalign_o} !== 3'b000) begin n_err++; $display("FAIL rb_flags: got %b expected 000", {stall_o, bus_err_o, misalign_o}); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (dmem_req_o !== 1'b0) begin n_err++; $display("FAIL rb_stays_idle: got %b expected 0", dmem_req_o); end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_store_sh();
        test_load_variants();
        test_store_variants();
        test_timeout();
        test_misalign();
        test_flush();
        test_rst_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
